// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the class arbiter: FSM encoding, default widths, one-hot decode.
package arbitro_pkg;

  localparam int unsigned DEF_DATA_W  = 12;
  localparam int unsigned DEF_CLASS_W = 2;

  // Widest one-hot the helper can produce; callers size-cast down to their own N_CH.
  localparam int unsigned MAX_CLASS_W = 4;
  localparam int unsigned MAX_CH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  function automatic logic [MAX_CH-1:0] onehot(input logic [MAX_CLASS_W-1:0] cls);
    logic [MAX_CH-1:0] r;
    r      = '0;
    r[cls] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/arbitro_cnt.sv
// Wrapping per-channel word counter with async active-low clear and increment enable.
module arbitro_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/arbitro_clases.sv
// Class arbiter: drains one show-ahead FIFO into N_CH per-class FIFOs with per-channel back-pressure.
// Define ARB_GLOBAL_STALL_EN to stall on any almost-full destination instead of the targeted one.
module arbitro_clases
  import arbitro_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CLASS_W = DEF_CLASS_W,
  parameter int unsigned N_CH    = 2 ** CLASS_W,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     fifo_data,
  input  logic                  fifo_empty,
  input  logic [N_CH-1:0]       almost_full,
  output logic                  pop,
  output logic [N_CH-1:0]       push,
  output logic [DATA_W-1:0]     data_out,
  output logic [1:0]            state,
  output logic [N_CH*CNT_W-1:0] word_cnt
);

  logic [CLASS_W-1:0] cls;
  logic               blocked;
  state_t             state_q;

  assign cls = fifo_data[DATA_W-1 -: CLASS_W];

`ifdef ARB_GLOBAL_STALL_EN
  assign blocked = |almost_full;
`else
  assign blocked = almost_full[cls];
`endif

  // Pop is combinational so a word moves in the same cycle the conditions hold.
  assign pop   = reset && !fifo_empty && !blocked;
  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push     <= '0;
      data_out <= '0;
      state_q  <= ST_IDLE;
    end else begin
      if (pop) begin
        push     <= N_CH'(onehot(MAX_CLASS_W'(cls)));
        data_out <= fifo_data;
      end else begin
        push <= '0;
      end
      if (fifo_empty) begin
        state_q <= ST_IDLE;
      end else if (blocked) begin
        state_q <= ST_BLOCKED;
      end else begin
        state_q <= ST_XFER;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_cnt
    arbitro_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .en   (pop && (cls == CLASS_W'(k))),
      .cnt  (word_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_arbitro_clases.sv
// Self-checking bench for arbitro_clases: directed scenarios plus randomized traffic vs. a queue-free model.
module tb_arbitro_clases;

  localparam int DATA_W = 12;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [DATA_W-1:0]     fifo_data;
  logic                  fifo_empty;
  logic [N_CH-1:0]       almost_full;
  logic                  pop;
  logic [N_CH-1:0]       push;
  logic [DATA_W-1:0]     data_out;
  logic [1:0]            state;
  logic [N_CH*CNT_W-1:0] word_cnt;

  arbitro_clases dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .almost_full(almost_full),
    .pop        (pop),
    .push       (push),
    .data_out   (data_out),
    .state      (state),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_push_ch;   // -1 when no push expected
  int m_data;
  int m_cnt [N_CH];
  int m_state;
  int pop_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int model_blocked(input int d, input logic [N_CH-1:0] af);
    int c;
    c = d / (1 << (DATA_W - 2));
`ifdef ARB_GLOBAL_STALL_EN
    return (af != 0) ? 1 : 0;
`else
    return af[c] ? 1 : 0;
`endif
  endfunction

  function automatic logic [N_CH*CNT_W-1:0] model_cnt_vec();
    logic [N_CH*CNT_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_CH; k++) v[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_push"}, 64'(push), (m_push_ch < 0) ? 64'd0 : (64'd1 << m_push_ch));
    chk({tag, "_data"}, 64'(data_out), 64'(m_data));
    chk({tag, "_state"}, 64'(state), 64'(m_state));
    chk({tag, "_cnt"}, 64'(word_cnt), 64'(model_cnt_vec()));
  endtask

  // One clock: drive at negedge, check pop, advance the model at posedge, check registered outputs.
  task automatic cycle(input logic r, input logic e, input logic [DATA_W-1:0] d,
                       input logic [N_CH-1:0] af);
    int exp_pop;
    int c;
    @(negedge clk);
    reset = r; fifo_empty = e; fifo_data = d; almost_full = af;
    #1;
    exp_pop  = (r && !e && model_blocked(int'(d), af) == 0) ? 1 : 0;
    pop_seen = int'(pop);
    chk("pop", 64'(pop), 64'(exp_pop));
    if (!r) begin
      m_push_ch = -1; m_data = 0; m_state = 0;
      for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
      check_outputs("async_rst");
    end
    @(posedge clk);
    c = int'(d) / (1 << (DATA_W - 2));
    if (r) begin
      if (exp_pop == 1) begin
        m_push_ch = c;
        m_data    = int'(d);
        m_cnt[c]  = (m_cnt[c] + 1) % (1 << CNT_W);
      end else begin
        m_push_ch = -1;
      end
      if (e) m_state = 0;
      else if (model_blocked(int'(d), af) == 1) m_state = 2;
      else m_state = 1;
    end
    #1;
    check_outputs("edge");
  endtask

  initial begin
    reset = 1'b0; fifo_empty = 1'b0; fifo_data = 12'hC05; almost_full = '0;
    m_push_ch = -1; m_data = 0; m_state = 0; pop_seen = 0;
    for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;

    // Reset held with a ready word, then release
    cycle(1'b0, 1'b0, 12'hC05, 4'b0000);
    cycle(1'b0, 1'b0, 12'hC05, 4'b0000);
    chk("rst_pop", 64'(pop_seen), 64'd0);
    chk("rst_cnt", 64'(word_cnt), 64'd0);
    cycle(1'b1, 1'b0, 12'hC05, 4'b0000);
    chk("rel_pop", 64'(pop_seen), 64'd1);
    chk("rel_push", 64'(push), 64'b1000);
    chk("rel_data", 64'(data_out), 64'hC05);
    chk("rel_cnt3", 64'(word_cnt[3*CNT_W +: CNT_W]), 64'd1);

    // Back-to-back classes 0..3
    cycle(1'b0, 1'b1, 12'h000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, DATA_W'((i << 10) | (i * 5 + 3)), 4'b0000);
      chk("b2b_pop", 64'(pop_seen), 64'd1);
      chk("b2b_push", 64'(push), 64'd1 << i);
    end
    chk("b2b_cnt", 64'(word_cnt), 64'h01010101);

    // Per-class stall on class 2
    cycle(1'b1, 1'b0, 12'h8AB, 4'b0100);
    chk("stall_pop", 64'(pop_seen), 64'd0);
    chk("stall_state", 64'(state), 64'd2);
    chk("stall_push", 64'(push), 64'd0);
    cycle(1'b1, 1'b0, 12'h8AB, 4'b0000);
    chk("unstall_push", 64'(push), 64'b0100);
    cycle(1'b1, 1'b0, 12'h8CD, 4'b0001);
`ifdef ARB_GLOBAL_STALL_EN
    chk("other_af_pop", 64'(pop_seen), 64'd0);
`else
    chk("other_af_pop", 64'(pop_seen), 64'd1);
    chk("other_af_push", 64'(push), 64'b0100);
`endif

    // Empty source
    cycle(1'b1, 1'b1, 12'h5A5, 4'b0000);
    chk("empty_pop", 64'(pop_seen), 64'd0);
    chk("empty_push", 64'(push), 64'd0);
    chk("empty_state", 64'(state), 64'd0);

    // Counter wrap on class 1, then reset mid-transfer
    cycle(1'b0, 1'b1, 12'h000, 4'b0000);
    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, DATA_W'(12'h400 | i), 4'b0000);
    chk("wrap_cnt1", 64'(word_cnt[CNT_W +: CNT_W]), 64'd0);
    chk("wrap_push", 64'(push), 64'b0010);
    cycle(1'b0, 1'b0, 12'h400, 4'b0000);
    chk("midrst_push", 64'(push), 64'd0);
    chk("midrst_cnt", 64'(word_cnt), 64'd0);

    // Non-targeted almost_full with class-3 head
    cycle(1'b1, 1'b0, 12'hF00, 4'b0001);
`ifdef ARB_GLOBAL_STALL_EN
    chk("glob_pop", 64'(pop_seen), 64'd0);
    chk("glob_state", 64'(state), 64'd2);
`else
    chk("glob_pop", 64'(pop_seen), 64'd1);
    chk("glob_state", 64'(state), 64'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, e;
      logic [N_CH-1:0] af;
      r  = ($urandom_range(0, 59) != 0);
      e  = ($urandom_range(0, 3) == 0);
      af = ($urandom_range(0, 1) == 0) ? 4'b0000 : N_CH'($urandom);
      cycle(r, e, DATA_W'($urandom), af);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
